// File: rtl/act_pack_writer.sv
// Packs a stream of int8 activations little-endian into memory words and writes them
// to consecutive word addresses, using byte enables on a short final word.
module act_pack_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_BYTES = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [LEN_WIDTH-1:0]             frame_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             mem_wr_en,
  input  logic                             mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
  output logic [DATA_WIDTH*PACK_BYTES-1:0] mem_wr_data,
  output logic [PACK_BYTES-1:0]            mem_wr_be,
  output logic                             busy,
  output logic                             done
);

  localparam int LANE_W = $clog2(PACK_BYTES);
  localparam int WORD_W = DATA_WIDTH * PACK_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  bytes_rcvd;
  logic [LEN_WIDTH-1:0]  bytes_inc;
  logic [LANE_W-1:0]     lane;
  logic [WORD_W-1:0]     pack;
  logic [WORD_W-1:0]     pack_merged;
  logic [PACK_BYTES-1:0] be_fill;
  logic                  take;
  logic                  wr_fire;
  logic                  last_byte;
  logic                  word_full;

  assign take      = in_valid && in_ready;
  assign wr_fire   = mem_wr_en && mem_wr_ready;
  assign bytes_inc = bytes_rcvd + 1'b1;
  assign last_byte = (bytes_inc == len);
  assign word_full = (lane == LANE_W'(PACK_BYTES - 1));

  // The pack register is cleared after every word, so lanes above the
  // current one are already zero when a partial word is emitted.
  generate
    for (genvar gi = 0; gi < PACK_BYTES; gi++) begin : g_lane
      assign pack_merged[gi*DATA_WIDTH +: DATA_WIDTH] =
        (lane == LANE_W'(gi)) ? in_data : pack[gi*DATA_WIDTH +: DATA_WIDTH];
      assign be_fill[gi] = (LANE_W'(gi) <= lane);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (frame_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        // A word still waiting on memory blocks the next byte.
        in_ready = !mem_wr_en || mem_wr_ready;
        if (take && last_byte) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (!mem_wr_en || mem_wr_ready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_addr   <= '0;
      len         <= '0;
      bytes_rcvd  <= '0;
      lane        <= '0;
      pack        <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_be   <= '0;
    end else begin
      if (wr_fire) begin
        mem_wr_en <= 1'b0;
      end
      if (state == IDLE && start && frame_len != '0) begin
        word_addr  <= base_addr;
        len        <= frame_len;
        bytes_rcvd <= '0;
        lane       <= '0;
        pack       <= '0;
      end
      // take implies the output register is free, so reloading it here never
      // disturbs a word that memory has not yet accepted.
      if (take) begin
        bytes_rcvd <= bytes_inc;
        if (word_full || last_byte) begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= word_addr;
          mem_wr_data <= pack_merged;
          mem_wr_be   <= be_fill;
          word_addr   <= word_addr + 1'b1;
          lane        <= '0;
          pack        <= '0;
        end else begin
          lane <= lane + 1'b1;
          pack <= pack_merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_pack_writer.sv
// Randomized scoreboard bench for act_pack_writer: a per-frame reference model
// queues expected writes, and an independent monitor checks every memory write.
module tb_act_pack_writer;
  localparam int DW = 8;
  localparam int PB = 4;
  localparam int AW = 16;
  localparam int LW = 20;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [DW*PB-1:0] data;
    logic [PB-1:0]    be;
    bit               last;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [LW-1:0]    frame_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             mem_wr_en;
  logic             mem_wr_ready = 1'b0;
  logic [AW-1:0]    mem_wr_addr;
  logic [DW*PB-1:0] mem_wr_data;
  logic [PB-1:0]    mem_wr_be;
  logic             busy;
  logic             done;

  int  errors = 0;
  int  checks = 0;
  int  ready_pct = 100;
  int  valid_pct = 100;
  int  stall_cnt = 0;
  int  done_count = 0;
  bit  expect_done = 0;
  bit  hold_valid = 0;
  logic [AW+DW*PB+PB:0] held;
  wr_t exp_q[$];

  act_pack_writer #(
    .DATA_WIDTH(DW), .PACK_BYTES(PB), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory-side ready driver, with an optional forced stall on the next write.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_cnt > 0 && mem_wr_en) begin
      mem_wr_ready = 1'b0;
      stall_cnt--;
    end else begin
      mem_wr_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: checks done timing, output stability under backpressure and every write.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      expect_done = 0;
      hold_valid  = 0;
    end else begin
      if (done) done_count++;
      if (expect_done) begin
        chk("done_latency", done, 1);
        expect_done = 0;
      end
      if (hold_valid) chk("wr_hold_stable", {mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be}, held);
      hold_valid = mem_wr_en && !mem_wr_ready;
      held = {mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be};
      if (hold_valid) chk("in_ready_stalled", in_ready, 0);
      if (mem_wr_en && mem_wr_ready) begin
        $display("write addr=%h data=%h be=%h", mem_wr_addr, mem_wr_data, mem_wr_be);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual addr=%h data=%h required no write", mem_wr_addr, mem_wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", mem_wr_addr, e.addr);
          chk("wr_data", mem_wr_data, e.data);
          chk("wr_be", mem_wr_be, e.be);
          if (e.last) expect_done = 1;
        end
      end
    end
  end

  task automatic run_frame(input logic [AW-1:0] base, input int len, input int first, input int abort_at);
    logic [7:0] bytes[$];
    int idx = 0;
    int guard = 0;
    int start_dones;
    bit word_end = 0;
    for (int i = 0; i < len; i++) bytes.push_back(first >= 0 ? 8'(first + i) : 8'($urandom));
    // Reference model: slice the byte list into words of PB bytes.
    for (int w = 0; w * PB < len; w++) begin
      wr_t e;
      int n;
      n = (len - w * PB < PB) ? len - w * PB : PB;
      e.addr = base + AW'(w);
      e.data = '0;
      for (int k = 0; k < n; k++) e.data = e.data | (32'(bytes[w*PB+k]) << (8 * k));
      e.be = 4'((1 << n) - 1);
      e.last = ((w + 1) * PB >= len);
      exp_q.push_back(e);
    end
    start_dones = done_count;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; frame_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); frame_len = LW'($urandom);
    @(negedge clk);
    chk("busy_after_start", busy, len > 0);
    if (len == 0) begin
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("zero_len_in_ready", in_ready, 0);
        chk("zero_len_wr_en", mem_wr_en, 0);
      end
      in_valid = 1'b0;
      chk("zero_len_done_count", done_count - start_dones, 1);
      return;
    end
    while (idx < len && idx != abort_at && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
      start = ($urandom_range(0, 19) == 0);
      frame_len = '0;
      in_valid = ($urandom_range(0, 99) < valid_pct);
      in_data = bytes[idx];
      @(negedge clk);
      if (word_end) chk("wr_en_latency", mem_wr_en, 1);
      word_end = 0;
      if (in_valid && !mem_wr_en) chk("in_ready_open", in_ready, 1);
      if (in_valid && in_ready) begin
        idx++;
        word_end = (idx % PB == 0) || (idx == len);
      end
    end
    if (guard >= 2000) chk("byte_loop_timeout", idx, len);
    if (idx == abort_at) begin
      @(posedge clk); #1;
      in_valid = 1'b0; start = 1'b0; rst = 1'b1;
      #1;
      chk("abort_outputs_zero", {in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be, busy, done}, 0);
      exp_q.delete();
      start_dones = done_count;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("no_done_after_abort", done_count - start_dones, 0);
      return;
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clk);
    if (word_end) chk("wr_en_latency", mem_wr_en, 1);
    chk("in_ready_after_last", in_ready, 0);
    in_valid = 1'b0;
    guard = 0;
    while (done_count == start_dones && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_count - start_dones, 1);
    chk("busy_after_done", busy, 0);
    chk("writes_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    #2;
    chk("reset_outputs", {in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be, busy, done}, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_frame(16'h0010, 8, 8'h01, -1);
    run_frame(16'h0100, 6, 8'hAA, -1);
    run_frame(16'h0200, 0, 0, -1);
    stall_cnt = 5;
    run_frame(16'h0010, 8, 8'h01, -1);
    run_frame(16'hFFFF, 8, 8'h11, -1);
    run_frame(16'h0020, 12, 8'h01, 5);
    run_frame(16'h0030, 4, 8'h50, -1);
    ready_pct = 60;
    valid_pct = 70;
    for (int f = 0; f < 20; f++) begin
      run_frame(AW'($urandom), $urandom_range(0, 19), -1, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
